mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/rv32i_types.sv | 66 ++++++
 rtl/mem_stage_align.sv | 44 ++++
 rtl/mem_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: memory-op and writeback-select encodings plus
// the EX/MEM and MEM/WB stage register layouts.
package rv32i_types;

    typedef enum logic [3:0] {
        mem_none, lb, lbu, lh, lhu, lw, sb, sh, sw
    } mem_op_t;

    typedef enum logic [2:0] {
        alu_out_rd, mem_rd, pc_next_rd, u_imm_rd, br_en_rd
    } rd_m_sel_t;

    typedef struct packed {
        logic      regf_we;
        rd_m_sel_t rd_m_sel;
        mem_op_t   mem_op;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid_s;
        wb_ctrl_t    wb_ctrl_s;
        logic [31:0] alu_out_s;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic [31:0] inst_s;
        logic [63:0] order_s;
        logic [31:0] u_imm_s;
        logic        br_en_s;
        logic [4:0]  rd_s;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid_s;
        wb_ctrl_t    wb_ctrl_s;
        logic [31:0] alu_out_s;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic [31:0] inst_s;
        logic [63:0] order_s;
        logic [31:0] u_imm_s;
        logic        br_en_s;
        logic [4:0]  rd_s;
        logic [31:0] mem_addr_s;
        logic [31:0] dmem_addr_s;
        logic [3:0]  mem_rmask_s;
        logic [3:0]  mem_wmask_s;
        logic [31:0] mem_wdata_s;
    } mem_wb_stage_reg_t;

    function automatic logic is_load(logic [3:0] op);
        return (op == lb) || (op == lbu) || (op == lh) || (op == lhu) || (op == lw);
    endfunction

    function automatic logic is_store(logic [3:0] op);
        return (op == sb) || (op == sh) || (op == sw);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane decode for a data access: read/write masks, lane-shifted store
// data and misalignment detection. Purely combinational.
module mem_align
    import rv32i_types::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_ea,
    input  logic [31:0] i_rs2_v,
    output logic [3:0]  o_rmask,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    logic [3:0] w_mask;

    always_comb begin
        w_mask       = 4'b0000;
        o_wdata      = 32'd0;
        o_misaligned = 1'b0;
        case (i_op)
            lb, lbu, sb: w_mask = 4'b0001 << i_ea[1:0];
            lh, lhu, sh: begin
                w_mask       = 4'b0011 << {i_ea[1], 1'b0};
                o_misaligned = i_ea[0];
            end
            lw, sw: begin
                w_mask       = 4'b1111;
                o_misaligned = |i_ea[1:0];
            end
            default: ;
        endcase
        case (i_op)
            sb:      o_wdata = {24'd0, i_rs2_v[7:0]} << {i_ea[1:0], 3'b000};
            sh:      o_wdata = {16'd0, i_rs2_v[15:0]} << {i_ea[1], 4'b0000};
            sw:      o_wdata = i_rs2_v;
            default: ;
        endcase
        // A misaligned access issues nothing; WB then treats it as an ALU result.
        o_rmask = (is_load(i_op)  && !o_misaligned) ? w_mask : 4'b0000;
        o_wmask = (is_store(i_op) && !o_misaligned) ? w_mask : 4'b0000;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues at most one outstanding data-memory access,
// stalls the pipeline until it responds, and registers the MEM/WB payload.
module mem_stage
    import rv32i_types::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  ex_mem_stage_reg_t      ex_mem_reg,
    input  logic                   dmem_resp,
    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_rmask,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    output logic                   move,
    output mem_wb_stage_reg_t      mem_wb_reg,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   r_outstanding;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    mem_wb_stage_reg_t      r_mem_wb;

    logic [31:0]       w_ea;
    logic [3:0]        w_rmask;
    logic [3:0]        w_wmask;
    logic [31:0]       w_wdata;
    logic              w_misaligned;
    logic              w_req_en;
    logic              w_issue;
    wb_ctrl_t          w_wb_ctrl;
    mem_wb_stage_reg_t w_mem_wb_next;

    assign w_ea = ex_mem_reg.alu_out_s;

    mem_align u_align (
        .i_op         (ex_mem_reg.wb_ctrl_s.mem_op),
        .i_ea         (w_ea),
        .i_rs2_v      (ex_mem_reg.rs2_v),
        .o_rmask      (w_rmask),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned)
    );

    // A response in the same cycle frees the slot, so the next access may issue.
    assign move       = !r_outstanding || dmem_resp;
    assign w_req_en   = ex_mem_reg.valid_s && move;
    assign dmem_addr  = {w_ea[31:2], 2'b00};
    assign dmem_rmask = w_req_en ? w_rmask : 4'b0000;
    assign dmem_wmask = w_req_en ? w_wmask : 4'b0000;
    assign dmem_wdata = (dmem_wmask != 4'b0000) ? w_wdata : 32'd0;
    assign w_issue    = (dmem_rmask != 4'b0000) || (dmem_wmask != 4'b0000);

    always_comb begin
        w_wb_ctrl = ex_mem_reg.wb_ctrl_s;
        if (w_misaligned) begin
            w_wb_ctrl.regf_we  = 1'b0;
            w_wb_ctrl.rd_m_sel = alu_out_rd;
        end
    end

    always_comb begin
        w_mem_wb_next             = '0;
        w_mem_wb_next.valid_s     = ex_mem_reg.valid_s;
        w_mem_wb_next.wb_ctrl_s   = w_wb_ctrl;
        w_mem_wb_next.alu_out_s   = ex_mem_reg.alu_out_s;
        w_mem_wb_next.rs1_s       = ex_mem_reg.rs1_s;
        w_mem_wb_next.rs2_s       = ex_mem_reg.rs2_s;
        w_mem_wb_next.rs1_v       = ex_mem_reg.rs1_v;
        w_mem_wb_next.rs2_v       = ex_mem_reg.rs2_v;
        w_mem_wb_next.pc_s        = ex_mem_reg.pc_s;
        w_mem_wb_next.pc_next_s   = ex_mem_reg.pc_next_s;
        w_mem_wb_next.inst_s      = ex_mem_reg.inst_s;
        w_mem_wb_next.order_s     = ex_mem_reg.order_s;
        w_mem_wb_next.u_imm_s     = ex_mem_reg.u_imm_s;
        w_mem_wb_next.br_en_s     = ex_mem_reg.br_en_s;
        w_mem_wb_next.rd_s        = ex_mem_reg.rd_s;
        w_mem_wb_next.mem_addr_s  = w_ea;
        w_mem_wb_next.dmem_addr_s = dmem_addr;
        w_mem_wb_next.mem_rmask_s = dmem_rmask;
        w_mem_wb_next.mem_wmask_s = dmem_wmask;
        w_mem_wb_next.mem_wdata_s = dmem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 1'b0;
            r_stall_cnt   <= '0;
            r_mem_wb      <= '0;
        end else begin
            if (w_issue)
                r_outstanding <= 1'b1;
            else if (dmem_resp)
                r_outstanding <= 1'b0;
            if (move)
                r_mem_wb <= w_mem_wb_next;
            else if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign mem_wb_reg   = r_mem_wb;
    assign stall_cycles = r_stall_cnt;

endmodule
